// File: rtl/es_nios2_debug_action_sequencer.sv
// ============================================================================
// es_nios2_debug_action_sequencer
// Queues JTAG debug actions and issues them one at a time to the OCI
// register/memory port over a req/ack handshake with a hang timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module es_nios2_debug_action_sequencer #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 38,
  parameter int TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         act_valid,
  input  logic [2:0]                   act_code,
  input  logic [DATA_W-1:0]            act_jdo,
  input  logic                         flush,
  input  logic                         err_clr,
  output logic                         cmd_req,
  output logic [2:0]                   cmd_code,
  output logic [DATA_W-1:0]            cmd_data,
  input  logic                         cmd_ack,
  output logic                         busy,
  output logic [$clog2(DEPTH):0]       fifo_count,
  output logic                         ovf_err,
  output logic                         tmo_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [2:0]        mem_code [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [15:0]       timer;
  state_t            state;

  logic full;
  logic tmo_hit;
  logic pop;
  logic push;
  logic ovf_set;
  logic tmo_set;

  // The timer only runs while cmd_req is visible, so the target always sees
  // exactly TIMEOUT request cycles before an abort.
  assign full    = (count == CNT_FULL);
  assign tmo_hit = (state == ISSUE) && cmd_req && !cmd_ack && (timer == TMO_LAST);
  assign pop     = (state == ISSUE) && cmd_req && (cmd_ack || (timer == TMO_LAST));
  assign push    = act_valid && !flush && (!full || pop);
  assign ovf_set = act_valid && !flush && full && !pop;
  assign tmo_set = tmo_hit && !flush;

  assign busy       = (count != '0) || (state != IDLE);
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= act_jdo;
      mem_code[wr_ptr] <= act_code;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      timer    <= '0;
      state    <= IDLE;
      cmd_req  <= 1'b0;
      cmd_code <= '0;
      cmd_data <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      timer    <= '0;
      state    <= IDLE;
      cmd_req  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      case (state)
        IDLE: begin
          if (count != '0) begin
            state    <= ISSUE;
            timer    <= '0;
            cmd_code <= mem_code[rd_ptr];
            cmd_data <= mem_data[rd_ptr];
          end
        end
        ISSUE: begin
          // First ISSUE cycle raises cmd_req; the head was latched on entry.
          if (!cmd_req) begin
            cmd_req <= 1'b1;
          end else if (pop) begin
            cmd_req <= 1'b0;
            state   <= IDLE;
            timer   <= '0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_err <= 1'b0;
      tmo_err <= 1'b0;
    end else begin
      if (ovf_set)      ovf_err <= 1'b1;
      else if (err_clr) ovf_err <= 1'b0;
      if (tmo_set)      tmo_err <= 1'b1;
      else if (err_clr) tmo_err <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_es_nios2_debug_action_sequencer.sv
// Directed bench for es_nios2_debug_action_sequencer: one task per scenario,
// inline comparisons against hand-computed values.
`default_nettype none

module tb_es_nios2_debug_action_sequencer;

  localparam int DEPTH   = 4;
  localparam int DATA_W  = 38;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              act_valid = 1'b0;
  logic [2:0]        act_code = '0;
  logic [DATA_W-1:0] act_jdo = '0;
  logic              flush = 1'b0;
  logic              err_clr = 1'b0;
  logic              cmd_ack = 1'b0;
  logic              cmd_req;
  logic [2:0]        cmd_code;
  logic [DATA_W-1:0] cmd_data;
  logic              busy;
  logic [2:0]        fifo_count;
  logic              ovf_err;
  logic              tmo_err;

  int n_checks = 0;
  int n_fail   = 0;

  es_nios2_debug_action_sequencer #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .act_valid(act_valid), .act_code(act_code),
    .act_jdo(act_jdo), .flush(flush), .err_clr(err_clr), .cmd_req(cmd_req),
    .cmd_code(cmd_code), .cmd_data(cmd_data), .cmd_ack(cmd_ack), .busy(busy),
    .fifo_count(fifo_count), .ovf_err(ovf_err), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!cmd_req && n < 20) begin
      step();
      n++;
    end
    ok = cmd_req;
  endtask

  task automatic push_one(input logic [2:0] code, input logic [DATA_W-1:0] jdo);
    act_valid = 1'b1; act_code = code; act_jdo = jdo;
    step();
    act_valid = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    n_checks++;
    if ({cmd_req, cmd_code, cmd_data, busy, fifo_count, ovf_err, tmo_err} !== '0) begin
      n_fail++;
      $display("FAIL %s: req=%0b code=%0d data=%0h busy=%0b cnt=%0d ovf=%0b tmo=%0b, required all 0",
               tag, cmd_req, cmd_code, cmd_data, busy, fifo_count, ovf_err, tmo_err);
    end
  endtask

  task automatic test_reset_single();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    check_idle_zero("reset_state");
    push_one(3'd5, 38'h12345);
    n_checks++;
    if (fifo_count !== 3'd1 || cmd_req !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL push_edge: cnt=%0d req=%0b busy=%0b, required 1/0/1", fifo_count, cmd_req, busy);
    end
    step();
    n_checks++;
    if (cmd_req !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_n1: req=%0b required 0", cmd_req);
    end
    step();
    n_checks++;
    if (cmd_req !== 1'b1 || cmd_code !== 3'd5 || cmd_data !== 38'h12345) begin
      n_fail++;
      $display("FAIL latency_n2: req=%0b code=%0d data=%0h, required 1/5/12345", cmd_req, cmd_code, cmd_data);
    end
    step(); step();
    cmd_ack = 1'b1;
    step();
    cmd_ack = 1'b0;
    n_checks++;
    if (cmd_req !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ack: req=%0b cnt=%0d busy=%0b, required 0/0/0", cmd_req, fifo_count, busy);
    end
  endtask

  task automatic test_overflow_order();
    bit ok;
    for (int i = 0; i < 5; i++) push_one(3'(i), 38'(100 + i));
    n_checks++;
    if (fifo_count !== 3'd4 || ovf_err !== 1'b1 || cmd_req !== 1'b1 || cmd_code !== 3'd0) begin
      n_fail++;
      $display("FAIL overflow: cnt=%0d ovf=%0b req=%0b code=%0d, required 4/1/1/0",
               fifo_count, ovf_err, cmd_req, cmd_code);
    end
    for (int i = 0; i < 4; i++) begin
      wait_req(ok);
      n_checks++;
      if (!ok || cmd_code !== 3'(i) || cmd_data !== 38'(100 + i)) begin
        n_fail++;
        $display("FAIL order_%0d: req=%0b code=%0d data=%0d, required 1/%0d/%0d",
                 i, cmd_req, cmd_code, cmd_data, i, 100 + i);
      end
      cmd_ack = 1'b1;
      step();
      cmd_ack = 1'b0;
    end
    n_checks++;
    if (fifo_count !== 3'd0 || cmd_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: cnt=%0d req=%0b busy=%0b, required 0/0/0", fifo_count, cmd_req, busy);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_checks++;
    if (ovf_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf=%0b required 0", ovf_err);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int hi = 0;
    push_one(3'd6, 38'h3f00000001);
    push_one(3'd7, 38'h0000000abc);
    wait_req(ok);
    n_checks++;
    if (!ok || cmd_code !== 3'd6 || cmd_data !== 38'h3f00000001) begin
      n_fail++;
      $display("FAIL tmo_head: req=%0b code=%0d data=%0h, required 1/6/3f00000001", cmd_req, cmd_code, cmd_data);
    end
    while (cmd_req && hi < 50) begin
      hi++;
      step();
    end
    n_checks++;
    if (hi !== 8 || tmo_err !== 1'b1 || fifo_count !== 3'd1) begin
      n_fail++;
      $display("FAIL tmo_len: high=%0d tmo=%0b cnt=%0d, required 8/1/1", hi, tmo_err, fifo_count);
    end
    wait_req(ok);
    n_checks++;
    if (!ok || cmd_code !== 3'd7 || cmd_data !== 38'h0000000abc) begin
      n_fail++;
      $display("FAIL tmo_next: req=%0b code=%0d data=%0h, required 1/7/abc", cmd_req, cmd_code, cmd_data);
    end
    cmd_ack = 1'b1; err_clr = 1'b1;
    step();
    cmd_ack = 1'b0; err_clr = 1'b0;
    n_checks++;
    if (tmo_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_clear: tmo=%0b busy=%0b, required 0/0", tmo_err, busy);
    end
  endtask

  task automatic test_full_push_pop();
    bit ok;
    for (int i = 1; i <= 4; i++) push_one(3'(i), 38'(200 + i));
    n_checks++;
    if (fifo_count !== 3'd4 || cmd_req !== 1'b1) begin
      n_fail++;
      $display("FAIL full_fill: cnt=%0d req=%0b, required 4/1", fifo_count, cmd_req);
    end
    act_valid = 1'b1; act_code = 3'd5; act_jdo = 38'd205; cmd_ack = 1'b1;
    step();
    act_valid = 1'b0; cmd_ack = 1'b0;
    n_checks++;
    if (fifo_count !== 3'd4 || ovf_err !== 1'b0 || cmd_req !== 1'b0) begin
      n_fail++;
      $display("FAIL full_push_pop: cnt=%0d ovf=%0b req=%0b, required 4/0/0", fifo_count, ovf_err, cmd_req);
    end
    for (int i = 2; i <= 5; i++) begin
      wait_req(ok);
      n_checks++;
      if (!ok || cmd_code !== 3'(i) || cmd_data !== 38'(200 + i)) begin
        n_fail++;
        $display("FAIL wrap_order_%0d: req=%0b code=%0d data=%0d, required 1/%0d/%0d",
                 i, cmd_req, cmd_code, cmd_data, i, 200 + i);
      end
      cmd_ack = 1'b1;
      step();
      cmd_ack = 1'b0;
    end
    n_checks++;
    if (busy !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL wrap_drain: busy=%0b cnt=%0d, required 0/0", busy, fifo_count);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) push_one(3'(i + 1), 38'(300 + i));
    n_checks++;
    if (cmd_req !== 1'b1 || fifo_count !== 3'd3) begin
      n_fail++;
      $display("FAIL flush_pre: req=%0b cnt=%0d, required 1/3", cmd_req, fifo_count);
    end
    flush = 1'b1; act_valid = 1'b1; act_code = 3'd4; act_jdo = 38'd399;
    step();
    flush = 1'b0; act_valid = 1'b0;
    n_checks++;
    if (cmd_req !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: req=%0b cnt=%0d busy=%0b, required 0/0/0", cmd_req, fifo_count, busy);
    end
    cmd_ack = 1'b1;
    step();
    cmd_ack = 1'b0;
    step();
    n_checks++;
    if (cmd_req !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0 || tmo_err !== 1'b0 || ovf_err !== 1'b0) begin
      n_fail++;
      $display("FAIL late_ack: req=%0b cnt=%0d busy=%0b tmo=%0b ovf=%0b, required all 0",
               cmd_req, fifo_count, busy, tmo_err, ovf_err);
    end
  endtask

  task automatic test_reset_and_clr_race();
    bit ok;
    push_one(3'd3, 38'd77);
    wait_req(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL race_req: req=%0b required 1", cmd_req);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_idle_zero("mid_issue_reset");
    push_one(3'd2, 38'd88);
    wait_req(ok);
    for (int i = 0; i < 7; i++) step();
    n_checks++;
    if (cmd_req !== 1'b1 || tmo_err !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_race: req=%0b tmo=%0b, required 1/0", cmd_req, tmo_err);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_checks++;
    if (tmo_err !== 1'b1 || cmd_req !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL set_wins: tmo=%0b req=%0b cnt=%0d, required 1/0/0", tmo_err, cmd_req, fifo_count);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_checks++;
    if (tmo_err !== 1'b0) begin
      n_fail++;
      $display("FAIL final_clear: tmo=%0b required 0", tmo_err);
    end
  endtask

  initial begin
    test_reset_single();
    test_overflow_order();
    test_timeout();
    test_full_push_pop();
    test_flush();
    test_reset_and_clr_race();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
